// File: rtl/seq_div.sv
// seq_div: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Start/done handshake; q/r/div_zero are held until the next accepted start.
// Optional feature macro: DIV_ZERO_BYPASS_EN (a zero divisor finishes after one
// cycle instead of running all WIDTH iterations; results are identical).
module seq_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned TW    = WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend shifts out at the top, quotient shifts in at the bottom
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dzl_q, dzl_d;   // divisor was zero at acceptance
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               dz_q, dz_d;

  logic [TW-1:0]      trial_c;
  logic               no_borrow_c;
  logic               trial_bit_unused;
  logic [WIDTH-1:0]   rem_nxt_c;
  logic [WIDTH-1:0]   quo_nxt_c;
  logic               last_c;
  logic               bypass_c;

  // Trial subtraction {rem, dividend_msb} - {0, divisor} via ~divisor + 1; carry-out means no borrow.
  assign trial_c          = {1'b0, rem_q, dvd_q[WIDTH-1]} + {1'b0, 1'b1, ~dvs_q} + TW'(1);
  assign no_borrow_c      = trial_c[TW-1];
  assign trial_bit_unused = trial_c[WIDTH];
  assign rem_nxt_c        = no_borrow_c ? trial_c[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign quo_nxt_c        = {dvd_q[WIDTH-2:0], no_borrow_c};
  assign last_c           = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef DIV_ZERO_BYPASS_EN
  assign bypass_c = dzl_q;
`else
  assign bypass_c = 1'b0;
`endif

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dzl_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dzl_q   <= dzl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state and next-output logic for IDLE -> CALC -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dzl_d   = dzl_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = a;
          dvs_d   = b;
          rem_d   = '0;
          cnt_d   = '0;
          dzl_d   = (b == '0);
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (bypass_c) begin
          q_d     = '1;
          r_d     = dvd_q;
          dz_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          rem_d = rem_nxt_c;
          dvd_d = quo_nxt_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_c) begin
            q_d     = quo_nxt_c;
            r_d     = rem_nxt_c;
            dz_d    = dzl_q;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign q        = q_q;
  assign r        = r_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed vector table, multi-cycle corner
// sequences (ignored start, mid-operation reset) and random operands checked
// against a plain a/b, a%b reference.
module tb_seq_div;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rstn;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_zero;

  int n_chk;
  int n_fail;
  int accepts;
  int done_seen;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t tbl[8];

  seq_div #(.WIDTH(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every done pulse seen on a rising edge.
  always @(posedge clk) if (done === 1'b1) done_seen++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: unsigned division; zero divisor gives all ones / dividend.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] mq, output logic [W-1:0] mr, output logic mdz);
    if (mb == 0) begin
      mq = '1; mr = ma; mdz = 1'b1;
    end else begin
      mq = ma / mb; mr = ma % mb; mdz = 1'b0;
    end
  endtask

  // One full operation; optionally pulses a spurious start while busy.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                        input int inject, input string nm);
    int elat, lat, bcnt;
    logic hold_ok;
    logic [W-1:0] pq, pr;
    elat = W;
`ifdef DIV_ZERO_BYPASS_EN
    if (tb == 0) elat = 1;
`endif
    @(negedge clk);
    pq = q; pr = r;
    start = 1'b1; a = ta; b = tb;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    accepts++;
    lat = 0; bcnt = 0; hold_ok = 1'b1;
    if (busy) bcnt++;
    check({nm, " busy_after_accept"}, 64'(busy), 64'(1));
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
      if (q !== pq || r !== pr) hold_ok = 1'b0;
      if (i == inject) begin
        start = 1'b1; a = 32'd9; b = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({nm, " latency"}, 64'(lat), 64'(elat));
    check({nm, " busy_cycles"}, 64'(bcnt), 64'(elat));
    check({nm, " qr_hold"}, 64'(hold_ok), 64'(1));
    check({nm, " busy_at_done"}, 64'(busy), 64'(0));
    check({nm, " q"}, 64'(q), 64'(eq));
    check({nm, " r"}, 64'(r), 64'(er));
    check({nm, " div_zero"}, 64'(div_zero), 64'(edz));
    @(posedge clk); #1;
    check({nm, " done_one_cycle"}, 64'(done), 64'(0));
  endtask

  // Watch n cycles with start low: no done, no busy may appear.
  task automatic idle_watch(input int n, input string nm);
    int dn, bz;
    dn = 0; bz = 0;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dn++;
      if (busy === 1'b1) bz++;
    end
    check({nm, " no_done"}, 64'(dn), 64'(0));
    check({nm, " no_busy"}, 64'(bz), 64'(0));
  endtask

  logic [W-1:0] ra, rb, rq, rr;
  logic         rdz;

  initial begin
    n_chk = 0; n_fail = 0; accepts = 0; done_seen = 0;
    rstn = 1'b0; start = 1'b0; a = '0; b = '0;

    tbl[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          dz: 1'b0};
    tbl[1] = '{a: 32'd3,          b: 32'd10,         q: 32'd0,          r: 32'd3,          dz: 1'b0};
    tbl[2] = '{a: 32'hFFFF_FFFF,  b: 32'h8000_0000,  q: 32'd1,          r: 32'h7FFF_FFFF,  dz: 1'b0};
    tbl[3] = '{a: 32'd5,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd5,          dz: 1'b1};
    tbl[4] = '{a: 32'd0,          b: 32'd1,          q: 32'd0,          r: 32'd0,          dz: 1'b0};
    tbl[5] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,          dz: 1'b0};
    tbl[6] = '{a: 32'd7,          b: 32'd7,          q: 32'd1,          r: 32'd0,          dz: 1'b0};
    tbl[7] = '{a: 32'd0,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd0,          dz: 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset q", 64'(q), 64'(0));
    check("reset r", 64'(r), 64'(0));
    check("reset div_zero", 64'(div_zero), 64'(0));
    @(negedge clk);
    rstn = 1'b1;
    idle_watch(5, "idle_after_reset");

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, 0, $sformatf("vec%0d", i));

    // Start while busy is ignored; a start right after done is accepted.
    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 5, "ignored_start");
    run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0, "start_after_done");
    idle_watch(40, "no_queued_start");

    // Mid-operation reset aborts and clears everything at once.
    run_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0, "pre_reset_dz");
    @(negedge clk);
    start = 1'b1; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'(0));
    check("abort done", 64'(done), 64'(0));
    check("abort q", 64'(q), 64'(0));
    check("abort r", 64'(r), 64'(0));
    check("abort div_zero", 64'(div_zero), 64'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle_watch(40, "after_abort");
    run_op(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 0, "post_abort");

    // Random operands with emphasis on b=1, a=b, b=0 and small divisors.
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd1;
        1: rb = ra;
        2: rb = 32'd0;
        3: rb = 32'($urandom_range(1, 255));
        4: ra = ra >> $urandom_range(0, 31);
        5: rb = rb >> $urandom_range(0, 31);
        default: ;
      endcase
      model(ra, rb, rq, rr, rdz);
      run_op(ra, rb, rq, rr, rdz, 0, $sformatf("rand%0d", i));
    end

    check("done_count_vs_accepts", 64'(done_seen), 64'(accepts));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
